// File: rtl/exec_sequencer_if.sv
// Handshake and execution-unit bus of the multi-beat SIMD command sequencer.
// The sequencer takes the slave side; the command/operand source, result sink and execution unit take the master side.
interface exec_sequencer_if #(
  parameter int BITS_ALUOP = 4,
  parameter int BITS_ARRAY = 64,
  parameter int BITS_DATA  = 8,
  parameter int BITS_BEATS = 8
);
  logic                  cmdValid;
  logic                  cmdReady;
  logic [BITS_ALUOP-1:0] cmdOpCode;
  logic [BITS_BEATS-1:0] cmdBeats;
  logic                  cmdChain;
  logic [BITS_DATA-1:0]  cmdCarryIn;

  logic                  opValid;
  logic                  opReady;
  logic [BITS_ARRAY-1:0] opArrayA;
  logic [BITS_ARRAY-1:0] opArrayB;

  logic [BITS_ALUOP-1:0] exOpCode;
  logic [BITS_ARRAY-1:0] exArrayA;
  logic [BITS_ARRAY-1:0] exArrayB;
  logic [BITS_DATA-1:0]  exAuxCarry;
  logic [BITS_ARRAY-1:0] exResult;
  logic [BITS_DATA-1:0]  exCarryTotal;

  logic                  resValid;
  logic                  resReady;
  logic [BITS_ARRAY-1:0] resData;
  logic [BITS_DATA-1:0]  resCarry;
  logic                  resLast;

  modport slave (
    input  cmdValid, cmdOpCode, cmdBeats, cmdChain, cmdCarryIn,
    output cmdReady,
    input  opValid, opArrayA, opArrayB,
    output opReady,
    output exOpCode, exArrayA, exArrayB, exAuxCarry,
    input  exResult, exCarryTotal,
    output resValid, resData, resCarry, resLast,
    input  resReady
  );

  modport master (
    output cmdValid, cmdOpCode, cmdBeats, cmdChain, cmdCarryIn,
    input  cmdReady,
    output opValid, opArrayA, opArrayB,
    input  opReady,
    input  exOpCode, exArrayA, exArrayB, exAuxCarry,
    output exResult, exCarryTotal,
    input  resValid, resData, resCarry, resLast,
    output resReady
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-beat command sequencer feeding a combinational 8-lane SIMD execution unit,
// with a one-entry result buffer and optional lane-carry chaining between beats.
module exec_sequencer #(
  parameter int BITS_ALUOP = 4,
  parameter int BITS_ARRAY = 64,
  parameter int BITS_DATA  = 8,
  parameter int BITS_BEATS = 8
) (
  input  logic              clk,
  input  logic              reset,
  exec_sequencer_if.slave   bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                state;
  state_t                stateNext;
  logic [BITS_ALUOP-1:0] opCodeReg;
  logic                  chainReg;
  logic [BITS_DATA-1:0]  carryReg;
  logic [BITS_BEATS-1:0] remaining;
  logic                  resValidReg;
  logic [BITS_ARRAY-1:0] resDataReg;
  logic [BITS_DATA-1:0]  resCarryReg;
  logic                  resLastReg;
  logic                  doneReg;

  logic                  cmdAccept;
  logic                  opAccept;
  logic                  opFire;
  logic                  resDrain;
  logic                  finishGo;
  logic [BITS_DATA-1:0]  carryRev;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // NOTE: every output of this block gets a default before the case; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    stateNext = state;
    cmdAccept = 1'b0;
    opAccept  = 1'b0;
    finishGo  = 1'b0;
    unique case (state)
      IDLE: begin
        cmdAccept = 1'b1;
        if (bus.cmdValid) stateNext = (bus.cmdBeats == '0) ? FINISH : RUN;
      end
      RUN: begin
        opAccept = !resValidReg || bus.resReady;
        if (bus.opValid && opAccept && remaining == BITS_BEATS'(1)) stateNext = FINISH;
      end
      FINISH: begin
        // Only the final beat can still be buffered here.
        finishGo = !resValidReg || (bus.resReady && resLastReg);
        if (finishGo) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign opFire   = bus.opValid && opAccept;
  assign resDrain = resValidReg && bus.resReady;

  // carryTotal bit i is lane i's carry-out; auxCarry bit (N-1-i) is lane i's carry-in.
  always_comb begin
    carryRev = '0;
    for (int i = 0; i < BITS_DATA; i++) carryRev[i] = bus.exCarryTotal[BITS_DATA-1-i];
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      opCodeReg   <= '0;
      chainReg    <= 1'b0;
      carryReg    <= '0;
      remaining   <= '0;
      resValidReg <= 1'b0;
      resDataReg  <= '0;
      resCarryReg <= '0;
      resLastReg  <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      doneReg <= finishGo;
      if (state == IDLE && bus.cmdValid) begin
        opCodeReg <= bus.cmdOpCode;
        chainReg  <= bus.cmdChain;
        carryReg  <= bus.cmdCarryIn;
        remaining <= bus.cmdBeats;
      end
      if (opFire) begin
        resDataReg  <= bus.exResult;
        resCarryReg <= bus.exCarryTotal;
        resValidReg <= 1'b1;
        resLastReg  <= (remaining == BITS_BEATS'(1));
        remaining   <= remaining - BITS_BEATS'(1);
        if (chainReg) carryReg <= carryRev;
      end else if (resDrain) begin
        resValidReg <= 1'b0;
      end
    end
  end

  assign bus.cmdReady   = cmdAccept;
  assign bus.opReady    = opAccept;
  assign bus.exOpCode   = (state == IDLE) ? '0 : opCodeReg;
  assign bus.exArrayA   = bus.opArrayA;
  assign bus.exArrayB   = bus.opArrayB;
  assign bus.exAuxCarry = carryReg;
  assign bus.resValid   = resValidReg;
  assign bus.resData    = resDataReg;
  assign bus.resCarry   = resCarryReg;
  assign bus.resLast    = resLastReg;
  assign busy           = (state != IDLE);
  assign done           = doneReg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: a lane-add/xor execution-unit stub, a result scoreboard,
// a table of command vectors and hand-written corner sequences.
module tb_exec_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  logic done;

  exec_sequencer_if sq ();

  exec_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sq),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  carry;
    logic        last;
  } res_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] beats;
    logic       chain;
    logic [7:0] carryIn;
    int         validPct;
    int         readyPct;
    int         expResults;
  } vec_t;

  res_t        sb[$];
  res_t        monRes;
  logic [71:0] monE;
  int vecCount = 0, missCount = 0;
  int fireCount = 0, drainCount = 0, doneCount = 0;
  logic [3:0]  mOp = '0;
  logic        mChain = 1'b0;
  logic [7:0]  mCarry = '0;
  int          mLeft = 0;
  int          d0, r0, f0, cyc;
  vec_t        vt[6];

  // Execution-unit model: op 1 = lane xor (no carry), otherwise lane add with carry-in.
  function automatic logic [71:0] euModel(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic [7:0] aux);
    logic [63:0] r;
    logic [7:0]  c;
    logic [8:0]  s;
    r = '0;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      if (op == 4'd1) begin
        r[i*8 +: 8] = a[i*8 +: 8] ^ b[i*8 +: 8];
      end else begin
        s = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]} + {8'd0, aux[7-i]};
        r[i*8 +: 8] = s[7:0];
        c[i] = s[8];
      end
    end
    return {c, r};
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = v[7-i];
    return o;
  endfunction

  assign {sq.exCarryTotal, sq.exResult} = euModel(sq.exOpCode, sq.exArrayA, sq.exArrayB, sq.exAuxCarry);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randOps();
    sq.opArrayA = {$urandom(), $urandom()};
    sq.opArrayB = {$urandom(), $urandom()};
  endtask

  task automatic issueCmd(input logic [3:0] op, input logic [7:0] beats, input logic chain,
                          input logic [7:0] cin);
    sq.cmdOpCode  = op;
    sq.cmdBeats   = beats;
    sq.cmdChain   = chain;
    sq.cmdCarryIn = cin;
    sq.cmdValid   = 1'b1;
    mOp = op; mChain = chain; mCarry = cin; mLeft = int'(beats);
    @(negedge clk);
    check("cmdReadyIdle", sq.cmdReady, 1);
    step();
    sq.cmdValid = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget);
    cyc = 0;
    while (doneCount < target && cyc < budget) begin
      sq.opValid = (mLeft > 0);
      randOps();
      step();
      cyc++;
    end
  endtask

  // Monitor: drains pop and compare, fires push the model's expected result.
  always @(negedge clk) begin
    if (!reset) begin
      if (sq.resValid === 1'b1 && sq.resReady === 1'b1) begin
        drainCount++;
        if (sb.size() == 0) begin
          vecCount++; missCount++;
          $display("FAIL unexpectedResult: got data %0h, want no result", sq.resData);
        end else begin
          monRes = sb.pop_front();
          check("resData", sq.resData, monRes.data);
          check("resCarry", sq.resCarry, monRes.carry);
          check("resLast", sq.resLast, monRes.last);
        end
      end
      if (sq.opValid === 1'b1 && sq.opReady === 1'b1) begin
        fireCount++;
        if (mLeft <= 0) begin
          vecCount++; missCount++;
          $display("FAIL extraFire: got beat beyond count, want none");
        end else begin
          check("exAuxCarry", sq.exAuxCarry, mCarry);
          check("exOpCode", sq.exOpCode, mOp);
          monE = euModel(mOp, sq.opArrayA, sq.opArrayB, mCarry);
          mLeft--;
          sb.push_back({monE[63:0], monE[71:64], (mLeft == 0)});
          if (mChain) mCarry = rev8(monE[71:64]);
        end
      end
      if (done === 1'b1) doneCount++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'd0, 8'd3, 1'b0, 8'hA5, 100, 100, 3};
    vt[1] = '{4'd0, 8'd5, 1'b1, 8'h00, 70, 50, 5};
    vt[2] = '{4'd1, 8'd4, 1'b1, 8'hFF, 50, 100, 4};
    vt[3] = '{4'd0, 8'd1, 1'b1, 8'h3C, 100, 30, 1};
    vt[4] = '{4'd0, 8'd6, 1'b1, 8'hFF, 60, 60, 6};
    vt[5] = '{4'd2, 8'd0, 1'b0, 8'h00, 100, 100, 0};

    sq.cmdValid = 0; sq.cmdOpCode = 0; sq.cmdBeats = 0; sq.cmdChain = 0; sq.cmdCarryIn = 0;
    sq.opValid = 0; sq.opArrayA = 0; sq.opArrayB = 0; sq.resReady = 1;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rstBusy", busy, 0);
    check("rstCmdReady", sq.cmdReady, 1);
    check("rstResValid", sq.resValid, 0);
    check("rstResData", sq.resData, 0);
    check("rstResCarry", sq.resCarry, 0);
    check("rstResLast", sq.resLast, 0);
    check("rstDone", done, 0);
    check("rstExOpCode", sq.exOpCode, 0);
    check("rstExAuxCarry", sq.exAuxCarry, 0);
    step();
    reset = 1'b0;
    step();

    // Table-driven commands with random valid/ready pressure
    foreach (vt[k]) begin
      d0 = doneCount; r0 = drainCount;
      issueCmd(vt[k].op, vt[k].beats, vt[k].chain, vt[k].carryIn);
      cyc = 0;
      while (doneCount == d0 && cyc < 500) begin
        sq.opValid  = (mLeft > 0) && ($urandom_range(99) < vt[k].validPct);
        randOps();
        sq.resReady = ($urandom_range(99) < vt[k].readyPct);
        step();
        cyc++;
      end
      sq.opValid = 0; sq.resReady = 1;
      repeat (3) step();
      check("vecDoneOnce", doneCount - d0, 1);
      check("vecResults", drainCount - r0, vt[k].expResults);
      check("vecSbEmpty", sb.size(), 0);
    end

    // Chain carry feedback: lane 0 overflows on beat 0
    d0 = doneCount;
    issueCmd(4'd0, 8'd2, 1'b1, 8'h00);
    sq.opValid = 1; sq.resReady = 1;
    sq.opArrayA = 64'h0000_0000_0000_00FF;
    sq.opArrayB = 64'h0101_0101_0101_0101;
    @(negedge clk);
    check("chainAux0", sq.exAuxCarry, 8'h00);
    step();
    sq.opArrayA = 64'h0; sq.opArrayB = 64'h0;
    @(negedge clk);
    check("chainAux1", sq.exAuxCarry, 8'h80);
    check("chainResCarry0", sq.resCarry, 8'h01);
    check("chainResData0", sq.resData, 64'h0101_0101_0101_0100);
    step();
    sq.opValid = 0;
    @(negedge clk);
    check("chainResData1", sq.resData, 64'h1);
    check("chainResLast1", sq.resLast, 1);
    waitDone(d0 + 1, 20);
    check("chainDone", doneCount - d0, 1);

    // Backpressure: buffer held full for four cycles
    d0 = doneCount; r0 = drainCount; f0 = fireCount;
    issueCmd(4'd0, 8'd3, 1'b0, 8'h11);
    sq.opValid = 1; sq.resReady = 0;
    for (int c = 0; c < 4; c++) begin
      randOps();
      if (c > 0) begin
        @(negedge clk);
        check("bpOpReadyFull", sq.opReady, 0);
      end
      step();
    end
    sq.resReady = 1;
    waitDone(d0 + 1, 50);
    sq.opValid = 0;
    repeat (3) step();
    check("bpFires", fireCount - f0, 3);
    check("bpResults", drainCount - r0, 3);
    check("bpDoneOnce", doneCount - d0, 1);

    // Zero-beat command
    d0 = doneCount; r0 = drainCount;
    issueCmd(4'd0, 8'd0, 1'b0, 8'h00);
    @(negedge clk);
    check("zeroCmdReady", sq.cmdReady, 0);
    check("zeroDoneEarly", done, 0);
    check("zeroResValidA", sq.resValid, 0);
    step();
    @(negedge clk);
    check("zeroDone", done, 1);
    check("zeroCmdReadyBack", sq.cmdReady, 1);
    check("zeroResValidB", sq.resValid, 0);
    step();
    check("zeroResults", drainCount - r0, 0);

    // Reset in the middle of a run
    d0 = doneCount; f0 = fireCount;
    issueCmd(4'd0, 8'd4, 1'b0, 8'h33);
    sq.opValid = 1; sq.resReady = 0; randOps();
    step();
    sq.resReady = 1; randOps();
    step();
    sq.opValid = 0; sq.resReady = 0;
    @(negedge clk);
    check("midFires", fireCount - f0, 2);
    check("midResValid", sq.resValid, 1);
    step();
    reset = 1'b1;
    sb.delete();
    mLeft = 0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("midRstBusy", busy, 0);
    check("midRstCmdReady", sq.cmdReady, 1);
    check("midRstResValid", sq.resValid, 0);
    check("midRstResData", sq.resData, 0);
    sq.resReady = 1;
    repeat (5) step();
    check("midRstNoDone", doneCount - d0, 0);

    // Streaming at full rate with a command held on cmdValid
    d0 = doneCount; f0 = fireCount; r0 = drainCount;
    sq.cmdOpCode = 4'd0; sq.cmdBeats = 8'd8; sq.cmdChain = 1'b1; sq.cmdCarryIn = 8'h0F;
    sq.cmdValid = 1;
    mOp = 4'd0; mChain = 1'b1; mCarry = 8'h0F; mLeft = 8;
    @(negedge clk);
    check("strCmdReadyIdle", sq.cmdReady, 1);
    step();
    sq.cmdBeats = 8'd0; sq.cmdOpCode = 4'd3;
    sq.opValid = 1; sq.resReady = 1;
    for (int c = 0; c < 8; c++) begin
      randOps();
      @(negedge clk);
      check("strOpReady", sq.opReady, 1);
      check("strCmdReadyRun", sq.cmdReady, 0);
      step();
    end
    sq.opValid = 0;
    check("strFires", fireCount - f0, 8);
    @(negedge clk);
    check("strLastBuffered", sq.resLast, 1);
    check("strNoDoneYet", done, 0);
    step();
    @(negedge clk);
    check("strDone", done, 1);
    check("strIdle", busy, 0);
    step();
    sq.cmdValid = 0;
    @(negedge clk);
    check("strHeldCmdTaken", busy, 1);
    waitDone(d0 + 2, 20);
    repeat (3) step();
    check("strDoneCount", doneCount - d0, 2);
    check("strResults", drainCount - r0, 8);
    check("strSbEmpty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-beat command sequencer in front of the 8-lane, 64-bit SIMD execution unit (8 ALUs × 8 bits, per-lane carry).
- Accepts a command (opcode, beat count, chain mode, initial carry), then streams operand pairs through the execution unit one beat per accepted operand.
- Registers each result and lane carry vector into a one-entry output buffer with valid/ready backpressure.
- In chain mode, feeds each beat's lane carries back as the next beat's carry-in, so each lane forms an N×8-bit arithmetic chain.

Parameters:
- BITS_ALUOP, 4, opcode width.
- BITS_ARRAY, 64, operand/result width.
- BITS_DATA, 8, lane count and carry-vector width.
- BITS_BEATS, 8, beat-count width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmdValid  input  1  command offered.
- cmdReady  output  1  sequencer can take a command (IDLE only).
- cmdOpCode  input  BITS_ALUOP  ALU function for the whole command.
- cmdBeats  input  BITS_BEATS  number of operand beats; 0 is legal.
- cmdChain  input  1  1 = carry feedback between beats.
- cmdCarryIn  input  BITS_DATA  auxCarry value for beat 0.
- opValid  input  1  operand pair offered.
- opReady  output  1  operand pair accepted this cycle.
- opArrayA  input  BITS_ARRAY  operand A.
- opArrayB  input  BITS_ARRAY  operand B.
- exOpCode  output  BITS_ALUOP  to execution unit opCode.
- exArrayA  output  BITS_ARRAY  to execution unit arrayA (combinational pass of opArrayA).
- exArrayB  output  BITS_ARRAY  to execution unit arrayB (combinational pass of opArrayB).
- exAuxCarry  output  BITS_DATA  to execution unit auxCarry.
- exResult  input  BITS_ARRAY  from execution unit executionResult (combinational).
- exCarryTotal  input  BITS_DATA  from execution unit carryTotal (combinational).
- resValid  output  1  result buffer full.
- resReady  input  1  consumer takes result.
- resData  output  BITS_ARRAY  registered result.
- resCarry  output  BITS_DATA  registered exCarryTotal, raw bit order.
- resLast  output  1  buffered result is the command's final beat.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when the command completes.

Behaviour:
- States: IDLE, RUN, FINISH.
- Reset (any state):
  - state=IDLE; resValid=0; resData=0; resCarry=0; resLast=0; done=0.
  - Internal opcode, carry and beat registers = 0.
  - Any in-flight command is discarded; its buffered result is dropped.
- IDLE:
  - cmdReady=1.
  - On cmdValid: latch opcode, chain, carryReg=cmdCarryIn, remaining=cmdBeats.
  - cmdBeats=0 -> FINISH; otherwise -> RUN.
- RUN:
  - opReady = opValid-independent qualifier: (!resValid || resReady).
  - Beat fires when opValid && opReady.
  - On a fire:
    - resData<=exResult; resCarry<=exCarryTotal; resValid<=1.
    - remaining decrements; resLast<=(remaining==1).
    - If chain: carryReg<=bit-reverse(exCarryTotal), so lane i carry-out feeds lane i carry-in (carryTotal bit i = lane i; auxCarry bit 7-i = lane i).
    - If not chain: carryReg holds cmdCarryIn for every beat.
  - On the last fire -> FINISH.
  - Result without a new fire, when resReady && resValid: resValid<=0.
  - Fire and drain in the same cycle: buffer reloads; resValid stays 1. Full throughput is one beat per cycle.
- FINISH:
  - opReady=0.
  - Wait until the buffer is empty or being drained (resValid==0, or resReady on the resLast entry).
  - Then done=1 for exactly one cycle and -> IDLE.
  - With beats=0: done asserts the cycle after acceptance; no result is produced.
- Execution-unit drive:
  - exOpCode = latched opcode in RUN/FINISH, 0 in IDLE.
  - exAuxCarry = carryReg.
  - The execution unit is combinational, so there is zero added latency: a result is visible on resData the cycle after its operand fires.
- cmdValid is ignored while not IDLE.
- opValid is ignored outside RUN.
- A beat count wraps to no other value: remaining never underflows.

Test Plan:
- Reset mid-RUN (beats=4, 2 fired, resValid=1) -> next cycle: state IDLE, resValid=0, busy=0, cmdReady=1, done never pulses.
- Chain, beats=2, cmdCarryIn=8'h00, stub returns exCarryTotal=8'h01 on beat 0 -> exAuxCarry=8'h80 during beat 1; resCarry=8'h01 on first result.
- Non-chain, beats=3, cmdCarryIn=8'hA5 -> exAuxCarry=8'hA5 on all 3 beats regardless of exCarryTotal; resLast=1 only on the third result.
- Backpressure: beats=3, opValid held 1, resReady=0 for 4 cycles then 1 -> opReady=0 while full; results emerge in order with no loss or duplication; done pulses once after the third result is drained.
- beats=0 -> cmdReady drops for 1 cycle, done=1 the next cycle, resValid never asserts.
- Streaming: beats=8, opValid and resReady held 1 -> 8 fires in 8 consecutive cycles; done one cycle after the last drain; cmdValid held high during RUN is not accepted until IDLE.
